// File: rtl/pipe_stage_buf_pkg.sv
// Package for pipe_stage_buf: FSM state type, counter width and
// occupancy encodings shared by the stage buffer and its users.
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } pipe_state_e;

    localparam int BUBBLE_CNT_W = 16;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    function automatic logic [1:0] occ_of(input pipe_state_e s);
        case (s)
            ONE:     return OCC_ONE;
            TWO:     return OCC_TWO;
            default: return OCC_EMPTY;
        endcase
    endfunction

endpackage

// File: rtl/pipe_stage_buf_if.sv
// Valid/ready packet bus between two pipeline stages.
//   in_*  : upstream side (valid, ready, ctrl, data)
//   out_* : downstream side (valid, ready, ctrl, data)
// slave  = view of the stage buffer, master = view of its environment.
interface pipe_stage_buf_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;

    modport slave (
        input  in_valid, in_ctrl, in_data, out_ready,
        output in_ready, out_valid, out_ctrl, out_data
    );

    modport master (
        output in_valid, in_ctrl, in_data, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data
    );
endinterface

// File: rtl/pipe_stage_buf_slot.sv
// pipe_slot: one packet register (ctrl + data) with load enable.
//   clk, rst_b : clock, synchronous active-high reset
//   clr        : loads RESET_CTRL into ctrl only; data holds
//   load       : captures d_ctrl/d_data
//   q_ctrl/q_data : held packet
module pipe_slot #(
    parameter int                DATA_W     = 32,
    parameter int                CTRL_W     = 8,
    parameter logic [CTRL_W-1:0] RESET_CTRL = '0
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic              clr,
    input  logic              load,
    input  logic [CTRL_W-1:0] d_ctrl,
    input  logic [DATA_W-1:0] d_data,
    output logic [CTRL_W-1:0] q_ctrl,
    output logic [DATA_W-1:0] q_data
);
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        ctrl_d = ctrl_q;
        data_d = data_q;
        if (clr) begin
            ctrl_d = RESET_CTRL;
        end else if (load) begin
            ctrl_d = d_ctrl;
            data_d = d_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            ctrl_q <= RESET_CTRL;
            data_q <= '0;
        end else begin
            ctrl_q <= ctrl_d;
            data_q <= data_d;
        end
    end

    assign q_ctrl = ctrl_q;
    assign q_data = data_q;
endmodule

// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: generic pipeline stage buffer with valid/ready flow
// control, optional skid slot, synchronous flush and a saturating
// bubble counter.
//   clk, rst_b   : clock, synchronous active-high reset
//   bus (slave)  : in_valid/in_ready/in_ctrl/in_data upstream,
//                  out_valid/out_ready/out_ctrl/out_data downstream
//   stall        : freeze, no accept and no issue
//   flush        : discard all held packets
//   occupancy    : held packets 0/1/2
//   bubble_cnt   : saturating count of cycles with out_valid=0
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int                DATA_W     = 32,
    parameter int                CTRL_W     = 8,
    parameter int                SKID       = 1,
    parameter logic [CTRL_W-1:0] RESET_CTRL = '0
) (
    input  logic                    clk,
    input  logic                    rst_b,
    pipe_stage_buf_if.slave         bus,
    input  logic                    stall,
    input  logic                    flush,
    output logic [1:0]              occupancy,
    output logic [BUBBLE_CNT_W-1:0] bubble_cnt
);
    function automatic logic [BUBBLE_CNT_W-1:0] sat_inc(input logic [BUBBLE_CNT_W-1:0] v);
        return (v == '1) ? v : v + BUBBLE_CNT_W'(1);
    endfunction

    pipe_state_e             state_q, state_d;
    logic [BUBBLE_CNT_W-1:0] bubble_q, bubble_d;

    logic              main_valid, out_valid, in_ready, accept, issue;
    logic              main_load, skid_load, slot_clr, main_from_skid;
    logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;
    logic [DATA_W-1:0] main_data, skid_data, main_in_data;

    // With the skid slot, in_ready depends only on state so out_ready
    // never reaches in_ready; without it the stage may only refill when
    // the head leaves in the same cycle. Reset forces in_ready low.
    always_comb begin
        main_valid = (state_q != EMPTY);
        out_valid  = main_valid & ~stall;
        if (SKID != 0) begin
            in_ready = ~rst_b & ~stall & ~flush & (state_q != TWO);
        end else begin
            in_ready = ~rst_b & ~stall & ~flush & (~main_valid | bus.out_ready);
        end
        accept = bus.in_valid & in_ready;
        issue  = out_valid & bus.out_ready;
    end

    always_comb begin
        state_d        = state_q;
        main_load      = 1'b0;
        skid_load      = 1'b0;
        slot_clr       = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_d  = EMPTY;
            slot_clr = 1'b1;
        end else if (!stall) begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d   = ONE;
                        main_load = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && issue) begin
                        main_load = 1'b1;
                    end else if (accept && (SKID != 0)) begin
                        state_d   = TWO;
                        skid_load = 1'b1;
                    end else if (issue) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    // in_ready is low here, so only the skid packet moves up
                    if (issue) begin
                        state_d        = ONE;
                        main_load      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
        bubble_d = out_valid ? bubble_q : sat_inc(bubble_q);
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q  <= EMPTY;
            bubble_q <= '0;
        end else begin
            state_q  <= state_d;
            bubble_q <= bubble_d;
        end
    end

    assign main_in_ctrl = main_from_skid ? skid_ctrl : bus.in_ctrl;
    assign main_in_data = main_from_skid ? skid_data : bus.in_data;

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_CTRL(RESET_CTRL)) u_main (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (slot_clr),
        .load   (main_load),
        .d_ctrl (main_in_ctrl),
        .d_data (main_in_data),
        .q_ctrl (main_ctrl),
        .q_data (main_data)
    );

    pipe_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .RESET_CTRL(RESET_CTRL)) u_skid (
        .clk    (clk),
        .rst_b  (rst_b),
        .clr    (slot_clr),
        .load   (skid_load),
        .d_ctrl (bus.in_ctrl),
        .d_data (bus.in_data),
        .q_ctrl (skid_ctrl),
        .q_data (skid_data)
    );

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_ctrl  = main_ctrl;
    assign bus.out_data  = main_data;
    assign occupancy     = occ_of(state_q);
    assign bubble_cnt    = bubble_q;
endmodule
